// File: rtl/fifo_rd_packer_pkg.sv
// Shared definitions for the FIFO read-side byte packer.
// Holds the default byte MSB index and lane count, plus helpers that
// derive the byte-count width and the packed word width.
package fifo_rd_packer_pkg;

  localparam int DEF_M     = 7;
  localparam int DEF_LANES = 4;

  // Count must reach LANES itself (a full assembly), hence the extra bit.
  localparam int CW = $clog2(DEF_LANES) + 1;

  function automatic int cnt_width(input int lanes);
    return $clog2(lanes) + 1;
  endfunction

  function automatic int word_width(input int m, input int lanes);
    return lanes * (m + 1);
  endfunction

endpackage

// File: rtl/fifo_rd_packer_pack_out_reg.sv
// Output word register with valid/ready hold.
// Ports:
//   clk, rst_n       read-domain clock, async active-low reset
//   load             capture load_data/load_keep and raise valid
//   load_data/keep   word and lane mask to present
//   ready            downstream accept
//   valid/data/keep  registered output port
// A load always wins over an acceptance in the same cycle, which gives
// back-to-back words with no idle cycle on the output.
module pack_out_reg
  import fifo_rd_packer_pkg::*;
#(
  parameter int W = word_width(DEF_M, DEF_LANES),
  parameter int K = DEF_LANES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic [K-1:0] load_keep,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic [K-1:0] keep
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      keep  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      keep  <= load_keep;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_rd_packer.sv
// Pops bytes from an async FIFO read port (1-cycle read latency) and packs
// LANES consecutive bytes into one word; the first byte lands in lane 0.
// A flush pulse forces out any partial word with a contiguous keep mask.
// Ports:
//   r_clk, r_reset   read-domain clock, async active-low reset
//   empty, r_en, din FIFO read interface (din valid the cycle after a pop)
//   flush            single-cycle partial-word request
//   out_valid/ready  output handshake; out_data, out_keep word and lane mask
//   busy             any byte held or in flight, flush pending, or word shown
module fifo_rd_packer
  import fifo_rd_packer_pkg::*;
#(
  parameter int M     = DEF_M,
  parameter int LANES = DEF_LANES
) (
  input  logic                    r_clk,
  input  logic                    r_reset,
  input  logic                    empty,
  output logic                    r_en,
  input  logic [M:0]              din,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*(M+1)-1:0]  out_data,
  output logic [LANES-1:0]        out_keep,
  output logic                    busy
);

  localparam int              CNTW = cnt_width(LANES);
  localparam int              WW   = word_width(M, LANES);
  localparam logic [CNTW-1:0] FULL = CNTW'(LANES);

  logic [CNTW-1:0] count_q, count_arr;
  logic            pending_q, flush_req_q;
  logic [WW-1:0]   asm_q, asm_arr;
  logic [LANES-1:0] load_keep;
  logic            slot_free, full_load, flush_load, load, flush_done;

  // Assembly including a byte arriving this cycle, so a word completed by
  // that byte (or cut by a flush) can load without an extra cycle.
  assign count_arr = count_q + CNTW'(pending_q);

  always_comb begin
    asm_arr = asm_q;
    for (int i = 0; i < LANES; i++) begin
      if (pending_q && (count_q == CNTW'(i))) asm_arr[i*(M+1) +: (M+1)] = din;
    end
  end

  always_comb begin
    load_keep = '0;
    for (int i = 0; i < LANES; i++) load_keep[i] = (CNTW'(i) < count_arr);
  end

  assign slot_free  = !out_valid || out_ready;
  assign full_load  = (count_arr == FULL) && slot_free;
  assign flush_load = flush_req_q && !pending_q && (count_q != '0) && slot_free;
  assign load       = full_load || flush_load;
  // With nothing in flight the flush resolves either by loading what is
  // held (slot free) or immediately when nothing is held.
  assign flush_done = flush_req_q && !pending_q && ((count_q == '0) || slot_free);

  // Gated by reset so the FIFO sees the pop request drop asynchronously.
  assign r_en = r_reset && !empty && !flush_req_q && (count_arr < FULL);

  always_ff @(posedge r_clk or negedge r_reset) begin
    if (!r_reset) begin
      count_q     <= '0;
      pending_q   <= 1'b0;
      flush_req_q <= 1'b0;
      asm_q       <= '0;
    end else begin
      pending_q <= r_en;
      if (load) begin
        count_q <= '0;
        asm_q   <= '0;   // keeps unused lanes zero for the next partial word
      end else begin
        count_q <= count_arr;
        asm_q   <= asm_arr;
      end
      if (flush_done)  flush_req_q <= 1'b0;
      else if (flush)  flush_req_q <= 1'b1;
    end
  end

  pack_out_reg #(.W(WW), .K(LANES)) u_out (
    .clk       (r_clk),
    .rst_n     (r_reset),
    .load      (load),
    .load_data (asm_arr),
    .load_keep (load_keep),
    .ready     (out_ready),
    .valid     (out_valid),
    .data      (out_data),
    .keep      (out_keep)
  );

  assign busy = (count_q != '0) || pending_q || flush_req_q || out_valid;

endmodule

// File: tb/tb_fifo_rd_packer.sv
module tb_fifo_rd_packer;
  localparam int LANES = 4;

  logic        r_clk = 1'b0;
  logic        r_reset, empty, r_en, flush, out_valid, out_ready, busy;
  logic [7:0]  din;
  logic [31:0] out_data;
  logic [3:0]  out_keep;

  always #5 r_clk = ~r_clk;

  fifo_rd_packer dut (
    .r_clk(r_clk), .r_reset(r_reset), .empty(empty), .r_en(r_en), .din(din),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_keep(out_keep), .busy(busy)
  );

  typedef struct { logic [31:0] d; logic [3:0] k; } word_t;
  typedef struct {
    byte unsigned b[4]; int n; bit fl; int nw; logic [31:0] d; logic [3:0] k;
  } vec_t;

  int checks = 0, failures = 0;
  byte unsigned src[$];   // bytes the emulated FIFO still holds
  byte unsigned acc[$];   // popped bytes not yet assigned to a word
  word_t exp_q[$];        // words the packer must emit, in order
  vec_t vt[6];
  logic hold_empty, prev_hold, s_ren, s_acc;
  logic [31:0] prev_data, last_data;
  logic [3:0]  prev_keep, last_keep;
  byte unsigned inflight;
  int n_acc, n_fire;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic cut_word();
    word_t w;
    w.d = '0; w.k = '0;
    foreach (acc[i]) begin
      w.d[8*i +: 8] = acc[i];
      w.k[i] = 1'b1;
    end
    exp_q.push_back(w);
    acc.delete();
  endtask

  // One read-clock cycle: inputs already driven at posedge+1, outputs sampled
  // at the falling edge, FIFO data returned one cycle after a pop.
  task automatic cycle();
    logic fire;
    word_t w;
    empty = hold_empty || (src.size() == 0);
    #4;
    s_ren = r_en;
    s_acc = out_valid && out_ready;
    check("r_en_while_empty", {31'd0, r_en && empty}, 32'd0);
    if (prev_hold) begin
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_data", out_data, prev_data);
      check("hold_keep", {28'd0, out_keep}, {28'd0, prev_keep});
    end
    prev_hold = out_valid && !out_ready;
    prev_data = out_data;
    prev_keep = out_keep;
    fire = r_en && !empty;
    if (fire) begin
      inflight = src.pop_front();
      acc.push_back(inflight);
      n_fire++;
      if (acc.size() == LANES) cut_word();
    end
    if (flush && acc.size() > 0) cut_word();
    if (s_acc) begin
      n_acc++;
      last_data = out_data;
      last_keep = out_keep;
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_word: got %h keep %b, none required", out_data, out_keep);
      end else begin
        w = exp_q.pop_front();
        check("word_data", out_data, w.d);
        check("word_keep", {28'd0, out_keep}, {28'd0, w.k});
      end
    end
    @(posedge r_clk); #1;
    if (fire) din = inflight;
    flush = 1'b0;
  endtask

  task automatic do_reset();
    r_reset = 1'b0; hold_empty = 1'b1; empty = 1'b1; flush = 1'b0;
    out_ready = 1'b1; din = '0;
    src.delete(); acc.delete(); exp_q.delete();
    prev_hold = 1'b0; n_acc = 0; n_fire = 0;
    repeat (2) @(posedge r_clk);
    #1 r_reset = 1'b1;
  endtask

  task automatic set_vec(input int i, input logic [31:0] bytes, input int n, input bit fl,
                         input int nw, input logic [31:0] d, input logic [3:0] k);
    for (int j = 0; j < 4; j++) vt[i].b[j] = bytes[31-8*j -: 8];
    vt[i].n = n; vt[i].fl = fl; vt[i].nw = nw; vt[i].d = d; vt[i].k = k;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int first, lows;
    int acc_t[$];

    set_vec(0, 32'h11223344, 4, 0, 1, 32'h44332211, 4'b1111);
    set_vec(1, 32'hA1B20000, 2, 1, 1, 32'h0000B2A1, 4'b0011);
    set_vec(2, 32'h5A000000, 1, 1, 1, 32'h0000005A, 4'b0001);
    set_vec(3, 32'h01020300, 3, 1, 1, 32'h00030201, 4'b0111);
    set_vec(4, 32'hDEADBEEF, 4, 1, 1, 32'hEFBEADDE, 4'b1111);
    set_vec(5, 32'h00000000, 0, 1, 0, 32'h0, 4'b0000);

    // Reset values, with the FIFO non-empty so r_en gating is exercised.
    r_reset = 1'b0; empty = 1'b0; flush = 1'b0; out_ready = 1'b1; din = '0;
    hold_empty = 1'b0;
    #12;
    check("rst_r_en", {31'd0, r_en}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_keep", {28'd0, out_keep}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);

    // Table-driven single-word cases, including flush boundaries.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      for (int i = 0; i < vt[v].n; i++) src.push_back(vt[v].b[i]);
      hold_empty = 1'b0;
      repeat (6) cycle();
      if (vt[v].fl) flush = 1'b1;
      repeat (8) cycle();
      check($sformatf("vec%0d_words", v), n_acc, vt[v].nw);
      if (vt[v].nw > 0) begin
        check($sformatf("vec%0d_data", v), last_data, vt[v].d);
        check($sformatf("vec%0d_keep", v), {28'd0, last_keep}, {28'd0, vt[v].k});
      end
      check($sformatf("vec%0d_busy", v), {31'd0, busy}, 32'd0);
    end

    // Throughput: 12 bytes, one bubble per word.
    do_reset();
    for (int i = 0; i < 12; i++) src.push_back(8'(i + 1));
    hold_empty = 1'b0;
    first = -1; lows = 0;
    for (int t = 0; t < 30; t++) begin
      cycle();
      if (s_ren && first < 0) first = t;
      if (first >= 0 && t <= first + 13 && !s_ren) lows++;
      if (s_acc) acc_t.push_back(t - first);
    end
    check("tput_words", acc_t.size(), 3);
    if (acc_t.size() == 3) check("tput_third_word_cycle", acc_t[2], 15);
    check("tput_bubbles", lows, 2);
    check("tput_pops", n_fire, 12);

    // Backpressure: first word held, second assembly stalls at LANES bytes.
    do_reset();
    for (int i = 0; i < 12; i++) src.push_back(8'(8'h30 + i));
    hold_empty = 1'b0; out_ready = 1'b0;
    repeat (15) cycle();
    check("bp_pops", n_fire, 8);
    check("bp_r_en", {31'd0, r_en}, 32'd0);
    check("bp_valid", {31'd0, out_valid}, 32'd1);
    check("bp_data", out_data, 32'h33323130);
    out_ready = 1'b1;
    repeat (25) cycle();
    check("bp_words", n_acc, 3);

    // Flush with a byte in flight; r_en held off until the flush resolves.
    do_reset();
    src.push_back(8'hC1); src.push_back(8'hC2); src.push_back(8'hC3);
    hold_empty = 1'b0;
    cycle(); cycle();
    hold_empty = 1'b1; flush = 1'b1;
    cycle();
    hold_empty = 1'b0;
    cycle();
    check("ff_r_en_blocked", {31'd0, s_ren}, 32'd0);
    cycle();
    check("ff_r_en_resume", {31'd0, s_ren}, 32'd1);
    check("ff_accept", {31'd0, s_acc}, 32'd1);
    check("ff_data", last_data, 32'h0000C2C1);
    check("ff_keep", {28'd0, last_keep}, 32'd3);
    flush = 1'b1;
    repeat (6) cycle();
    check("ff_tail_words", n_acc, 2);

    // Mid-operation reset with a held word and three assembled bytes.
    do_reset();
    for (int i = 0; i < 7; i++) src.push_back(8'(8'h10 + i));
    hold_empty = 1'b0; out_ready = 1'b0;
    repeat (12) cycle();
    src.push_back(8'h17); empty = 1'b0;
    #1;
    check("mr_pre_valid", {31'd0, out_valid}, 32'd1);
    check("mr_pre_r_en", {31'd0, r_en}, 32'd1);
    #1 r_reset = 1'b0;
    #1;
    check("mr_r_en", {31'd0, r_en}, 32'd0);
    check("mr_valid", {31'd0, out_valid}, 32'd0);
    check("mr_data", out_data, 32'd0);
    check("mr_keep", {28'd0, out_keep}, 32'd0);
    check("mr_busy", {31'd0, busy}, 32'd0);
    do_reset();
    src.push_back(8'h81); src.push_back(8'h82); src.push_back(8'h83); src.push_back(8'h84);
    hold_empty = 1'b0;
    repeat (8) cycle();
    check("mr_clean_words", n_acc, 1);
    check("mr_clean_data", last_data, 32'h84838281);
    check("mr_clean_keep", {28'd0, last_keep}, 32'hF);

    // Randomized traffic against the byte-stream reference.
    do_reset();
    for (int t = 0; t < 800; t++) begin
      hold_empty = ($urandom_range(0, 9) < 3);
      out_ready  = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 19) == 0) flush = 1'b1;
      while (src.size() < 4) src.push_back(8'($urandom));
      cycle();
    end
    hold_empty = 1'b1; out_ready = 1'b1;
    repeat (3) cycle();
    flush = 1'b1;
    repeat (15) cycle();
    check("rand_left_over", exp_q.size(), 0);
    check("rand_busy", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
